// File: rtl/asap2_pkg.sv
// ============================================================================
// Module      : asap2_pkg
// Description : Shared opcode, state and control constants for the ASAP2 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package asap2_pkg;

    localparam int c_opc_w = 4;

    localparam logic [c_opc_w-1:0] c_opc_nop = 4'd0;
    localparam logic [c_opc_w-1:0] c_opc_lda = 4'd1;
    localparam logic [c_opc_w-1:0] c_opc_add = 4'd2;
    localparam logic [c_opc_w-1:0] c_opc_sub = 4'd3;
    localparam logic [c_opc_w-1:0] c_opc_sta = 4'd4;
    localparam logic [c_opc_w-1:0] c_opc_ldi = 4'd5;
    localparam logic [c_opc_w-1:0] c_opc_jmp = 4'd6;
    localparam logic [c_opc_w-1:0] c_opc_jc  = 4'd7;
    localparam logic [c_opc_w-1:0] c_opc_jz  = 4'd8;
    localparam logic [c_opc_w-1:0] c_opc_out = 4'd14;
    localparam logic [c_opc_w-1:0] c_opc_hlt = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/asap2_alu.sv
// ============================================================================
// Module      : asap2_alu
// Description : Combinational add/subtract with carry-out and zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asap2_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] y_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_b;

    // Subtraction is A + ~B + 1, so carry-out means "no borrow" (A >= B).
    always_comb begin
        w_b     = sub_i ? ~b_i : b_i;
        w_sum   = {1'b0, a_i} + {1'b0, w_b} + {{DATA_W{1'b0}}, sub_i};
        y_o     = w_sum[DATA_W-1:0];
        carry_o = w_sum[DATA_W];
        zero_o  = (w_sum[DATA_W-1:0] == '0);
    end

endmodule

`default_nettype wire

// File: rtl/asap2_core.sv
// ============================================================================
// Module      : asap2_core
// Description : Accumulator CPU with internal program/data memory and loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asap2_core
    import asap2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ce_i,
    input  logic              run_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              halted_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              carry_o,
    output logic              zero_o
);

    generate
        if (DATA_W < 8 || ADDR_W > DATA_W - 4) begin : g_bad_params
            $error("asap2_core: need DATA_W >= 8 and ADDR_W <= DATA_W-4");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rd_pc;
    logic [DATA_W-1:0] w_rd_addr;
    logic [c_opc_w-1:0] w_opcode;
    logic [ADDR_W-1:0] w_ir_addr;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_c;
    logic              w_alu_z;

    assign w_rd_pc   = mem_q[pc_q];
    assign w_rd_addr = mem_q[addr_q];
    assign w_opcode  = ir_q[DATA_W-1 -: c_opc_w];
    assign w_ir_addr = ir_q[ADDR_W-1:0];

    asap2_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i     (acc_q),
        .b_i     (w_rd_addr),
        .sub_i   (w_opcode == c_opc_sub),
        .y_o     (w_alu_y),
        .carry_o (w_alu_c),
        .zero_o  (w_alu_z)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        c_d         = c_q;
        z_d         = z_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = ld_addr_i;
        w_mem_wdata = ld_data_i;

        if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    pc_d     = '0;
                    w_mem_we = ld_we_i;
                    if (run_i) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (!run_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        ir_d    = w_rd_pc;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (w_opcode)
                        c_opc_lda, c_opc_add, c_opc_sub: begin
                            addr_d  = w_ir_addr;
                            state_d = ST_MEM;
                        end
                        c_opc_sta: begin
                            w_mem_we    = 1'b1;
                            w_mem_waddr = w_ir_addr;
                            w_mem_wdata = acc_q;
                        end
                        c_opc_ldi: acc_d = DATA_W'(ir_q[DATA_W-5:0]);
                        c_opc_jmp: pc_d = w_ir_addr;
                        c_opc_jc:  if (c_q) pc_d = w_ir_addr;
                        c_opc_jz:  if (z_q) pc_d = w_ir_addr;
                        c_opc_out: begin
                            out_data_d  = acc_q;
                            out_valid_d = 1'b1;
                        end
                        c_opc_hlt: state_d = ST_HALT;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    state_d = ST_FETCH;
                    if (w_opcode == c_opc_lda) begin
                        acc_d = w_rd_addr;
                    end else begin
                        acc_d = w_alu_y;
                        c_d   = w_alu_c;
                        z_d   = w_alu_z;
                    end
                end
                ST_HALT: begin
                    w_mem_we = ld_we_i;
                    if (!run_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // No write may land while reset is held, even in IDLE.
        w_mem_we = w_mem_we & rst_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            addr_q      <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            z_q         <= z_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) mem_q[w_mem_waddr] <= w_mem_wdata;
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign halted_o    = (state_q == ST_HALT);
    assign busy_o      = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);
    assign pc_o        = pc_q;
    assign carry_o     = c_q;
    assign zero_o      = z_q;

endmodule

`default_nettype wire

// File: tb/tb_asap2_core.sv
// ============================================================================
// Module      : tb_asap2_core
// Description : Scoreboard bench for asap2_core against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asap2_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ce_i;
    logic              run_i;
    logic              ld_we_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic [DATA_W-1:0] ld_data_i;
    logic [DATA_W-1:0] out_data_o;
    logic              out_valid_o;
    logic              halted_o;
    logic              busy_o;
    logic [ADDR_W-1:0] pc_o;
    logic              carry_o;
    logic              zero_o;

    asap2_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ce_i        (ce_i),
        .run_i       (run_i),
        .ld_we_i     (ld_we_i),
        .ld_addr_i   (ld_addr_i),
        .ld_data_i   (ld_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .halted_o    (halted_o),
        .busy_o      (busy_o),
        .pc_o        (pc_o),
        .carry_o     (carry_o),
        .zero_o      (zero_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors    = 0;
    int miscompares = 0;

    // Architectural model state: memory, accumulator, flags, last output.
    int   m_mem [16];
    int   m_a, m_c, m_z, m_out, exp_pc;
    int   exp_q [$];
    logic [7:0] img [16];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i && out_valid_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got %0d, expected no output", out_data_o);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_data_o) != e) begin
                    miscompares++;
                    $display("FAIL out_data: got %0d, expected %0d", out_data_o, e);
                end
            end
        end
    end

    function automatic logic [7:0] ins(input int op, input int opr);
        return 8'(op * 16 + opr);
    endfunction

    task automatic model_run();
        int pc;
        int steps;
        bit done;
        pc = 0; steps = 0; done = 0;
        while (!done && steps < 1000) begin
            int op, opr, m;
            op  = m_mem[pc] / 16;
            opr = m_mem[pc] % 16;
            m   = m_mem[opr];
            pc  = (pc + 1) % 16;
            steps++;
            case (op)
                1:  m_a = m;
                2:  begin m_c = (m_a + m > 255); m_a = (m_a + m) % 256; m_z = (m_a == 0); end
                3:  begin m_c = (m_a >= m); m_a = (m_a - m + 256) % 256; m_z = (m_a == 0); end
                4:  m_mem[opr] = m_a;
                5:  m_a = opr;
                6:  pc = opr;
                7:  if (m_c != 0) pc = opr;
                8:  if (m_z != 0) pc = opr;
                14: begin exp_q.push_back(m_a); m_out = m_a; end
                15: done = 1;
                default: ;
            endcase
        end
        exp_pc = pc;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_prog(input int n);
        run_i = 1'b0;
        ce_i  = 1'b1;
        tick();
        tick();
        for (int a = 0; a < n; a++) begin
            ld_we_i   = 1'b1;
            ld_addr_i = 4'(a);
            ld_data_i = img[a];
            m_mem[a]  = int'(img[a]);
            tick();
        end
        ld_we_i = 1'b0;
    endtask

    task automatic run_prog(input bit rand_ce, input bit poke);
        int cyc;
        model_run();
        run_i = 1'b1;
        cyc   = 0;
        while (!halted_o && cyc < 4000) begin
            ce_i      = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_we_i   = poke && busy_o && ($urandom_range(0, 1) == 1);
            ld_addr_i = 4'($urandom);
            ld_data_i = 8'($urandom);
            tick();
            cyc++;
        end
        ld_we_i = 1'b0;
        ce_i    = 1'b1;
        check("halt_reached", int'(halted_o), 1);
        check("outputs_pending", exp_q.size(), 0);
        check("pc_at_halt", int'(pc_o), exp_pc);
        check("carry_at_halt", int'(carry_o), m_c);
        check("zero_at_halt", int'(zero_o), m_z);
        check("out_data_held", int'(out_data_o), m_out);
        exp_q.delete();
        run_i = 1'b0;
        tick();
        check("idle_after_halt", int'(halted_o) + int'(busy_o), 0);
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},        int'(pc_o), 0);
        check({tag, "_out_data"},  int'(out_data_o), 0);
        check({tag, "_out_valid"}, int'(out_valid_o), 0);
        check({tag, "_halted"},    int'(halted_o), 0);
        check({tag, "_busy"},      int'(busy_o), 0);
        check({tag, "_carry"},     int'(carry_o), 0);
        check({tag, "_zero"},      int'(zero_o), 0);
    endtask

    task automatic clear_img();
        for (int a = 0; a < 16; a++) img[a] = 8'h00;
    endtask

    initial begin
        rst_i = 1'b0; ce_i = 1'b1; run_i = 1'b0;
        ld_we_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
        m_a = 0; m_c = 0; m_z = 0; m_out = 0; exp_pc = 0;
        for (int a = 0; a < 16; a++) m_mem[a] = 0;
        tick(); tick(); tick();
        check_reset_values("reset");
        rst_i = 1'b1;
        tick();

        // 28 + 14 = 42
        clear_img();
        img[0] = ins(1, 14); img[1] = ins(2, 15); img[2] = ins(14, 0); img[3] = ins(15, 0);
        img[14] = 8'd28; img[15] = 8'd14;
        load_prog(16);
        run_prog(0, 0);

        // 5 - 7 borrows; 7 - 7 is zero with carry
        clear_img();
        img[0] = ins(5, 5); img[1] = ins(3, 15); img[2] = ins(14, 0); img[3] = ins(15, 0);
        img[15] = 8'd7;
        load_prog(16);
        run_prog(0, 0);
        img[0] = ins(5, 7);
        load_prog(1);
        run_prog(0, 0);

        // 200 + 100 carries; JZ falls through, JC lands at 9
        clear_img();
        img[0] = ins(1, 14); img[1] = ins(2, 15); img[2] = ins(8, 8); img[3] = ins(7, 9);
        img[4] = ins(15, 0); img[8] = ins(15, 0); img[9] = ins(14, 0); img[10] = ins(15, 0);
        img[14] = 8'd200; img[15] = 8'd100;
        load_prog(16);
        run_prog(0, 0);

        // Countdown loop, then again with a stuttering clock enable
        clear_img();
        img[0] = ins(5, 3); img[1] = ins(3, 15); img[2] = ins(14, 0); img[3] = ins(8, 5);
        img[4] = ins(6, 1); img[5] = ins(15, 0); img[15] = 8'd1;
        load_prog(16);
        run_prog(0, 0);
        run_prog(1, 0);

        // Asynchronous reset while the ADD sits in its memory cycle
        clear_img();
        img[0] = ins(1, 14); img[1] = ins(2, 15); img[2] = ins(14, 0); img[3] = ins(15, 0);
        img[14] = 8'd28; img[15] = 8'd14;
        load_prog(16);
        run_i = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("busy_before_reset", int'(busy_o), 1);
        check("pc_before_reset", int'(pc_o), 2);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_values("midrst");
        m_a = 0; m_c = 0; m_z = 0; m_out = 0;
        tick();
        run_i = 1'b0;
        rst_i = 1'b1;
        tick();
        run_prog(0, 0);

        // Jump to the last word; fetch must wrap to address 0
        clear_img();
        img[0] = ins(8, 5); img[1] = ins(1, 13); img[2] = ins(2, 13); img[3] = ins(14, 0);
        img[4] = ins(6, 15); img[5] = ins(5, 9); img[6] = ins(14, 0); img[7] = ins(15, 0);
        img[13] = 8'd0; img[15] = ins(0, 0);
        load_prog(16);
        run_prog(0, 0);

        // Random forward-only programs, loader strobed while busy, then data readback
        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < 11; a++) begin
                int op, opr;
                op  = $urandom_range(0, 15);
                opr = $urandom_range(0, 15);
                if (op >= 6 && op <= 8) opr = $urandom_range(a + 1, 11);
                if (op == 4) opr = $urandom_range(12, 15);
                img[a] = ins(op, opr);
            end
            img[11] = ins(15, 0);
            for (int a = 12; a < 16; a++) img[a] = 8'($urandom);
            load_prog(16);
            run_prog(it[0], 1);
            for (int a = 0; a < 4; a++) begin
                img[2*a]     = ins(1, 12 + a);
                img[2*a + 1] = ins(14, 0);
            end
            img[8] = ins(15, 0);
            load_prog(9);
            run_prog(!it[0], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
